// File: rtl/timer_multi.sv
// rtl/timer_multi.sv - mode-selectable prescaled down-counting timer (alarm, timeout, pulse, strobe)
// Outputs are registered; next state is formed combinationally from put > cancel > tick.
module timer_multi #(
  parameter int W  = 8,
  parameter int PW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [W-1:0]  value,
  input  logic          put,
  input  logic [1:0]    mode,
  input  logic [PW-1:0] prescale,
  input  logic          pause,
  input  logic          cancel,
  output logic          out,
  output logic          busy,
  output logic [W-1:0]  count
);

  typedef enum logic [1:0] {
    ALARM   = 2'd0,
    TIMEOUT = 2'd1,
    PULSE   = 2'd2,
    STROBE  = 2'd3
  } mode_t;

  mode_t         mode_q, mode_n;
  logic [W-1:0]  cnt_q, cnt_n;
  logic [W-1:0]  reload_q, reload_n;
  logic [PW-1:0] presc_q, presc_n;
  logic [PW-1:0] pre_q, pre_n;
  logic          running_q, running_n;
  logic          out_q, out_n;
  logic          tick;
  mode_t         mode_in;

  assign mode_in = mode_t'(mode);
  assign tick    = running_q && !pause && (presc_q == pre_q);

  always_comb begin
    mode_n    = mode_q;
    cnt_n     = cnt_q;
    reload_n  = reload_q;
    presc_n   = presc_q;
    pre_n     = pre_q;
    running_n = running_q;
    out_n     = out_q;
    if (put) begin
      mode_n   = mode_in;
      pre_n    = prescale;
      presc_n  = '0;
      reload_n = value;
      if (value != '0) begin
        cnt_n     = value;
        running_n = 1'b1;
        out_n     = (mode_in == PULSE);
      end else begin
        // Zero load: only TIMEOUT reports, and it reports as already expired.
        cnt_n     = '0;
        running_n = 1'b0;
        out_n     = (mode_in == TIMEOUT);
      end
    end else if (cancel) begin
      cnt_n     = '0;
      presc_n   = '0;
      running_n = 1'b0;
      out_n     = 1'b0;
    end else begin
      // Single-cycle modes drop out every clock unless this clock expires.
      if (mode_q == ALARM || mode_q == STROBE) out_n = 1'b0;
      if (tick) begin
        presc_n = '0;
        if (cnt_q == W'(1)) begin
          case (mode_q)
            ALARM, TIMEOUT: begin
              out_n     = 1'b1;
              cnt_n     = '0;
              running_n = 1'b0;
            end
            PULSE: begin
              out_n     = 1'b0;
              cnt_n     = '0;
              running_n = 1'b0;
            end
            default: begin
              out_n = 1'b1;
              cnt_n = reload_q;
            end
          endcase
        end else begin
          cnt_n = cnt_q - W'(1);
        end
      end else if (running_q && !pause) begin
        presc_n = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q    <= ALARM;
      cnt_q     <= '0;
      reload_q  <= '0;
      presc_q   <= '0;
      pre_q     <= '0;
      running_q <= 1'b0;
      out_q     <= 1'b0;
    end else begin
      mode_q    <= mode_n;
      cnt_q     <= cnt_n;
      reload_q  <= reload_n;
      presc_q   <= presc_n;
      pre_q     <= pre_n;
      running_q <= running_n;
      out_q     <= out_n;
    end
  end

  assign out   = out_q;
  assign busy  = running_q;
  assign count = cnt_q;

endmodule

// File: tb/tb_timer_multi.sv
// tb/tb_timer_multi.sv - scoreboard bench for timer_multi with directed per-edge expectations
// Expected edge results are queued at stimulus time; a forked monitor compares on each falling edge.
module tb_timer_multi;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] value;
  logic       put;
  logic [1:0] mode;
  logic [3:0] prescale;
  logic       pause;
  logic       cancel;
  logic       out;
  logic       busy;
  logic [7:0] count;

  timer_multi #(.W(8), .PW(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .value    (value),
    .put      (put),
    .mode     (mode),
    .prescale (prescale),
    .pause    (pause),
    .cancel   (cancel),
    .out      (out),
    .busy     (busy),
    .count    (count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int    at;
    logic  o;
    logic  b;
    int    c;
    string name;
  } rec_t;

  rec_t  sb[$];
  int    total = 0;
  int    bad = 0;
  int    base = 0;
  string tname = "reset";

  task automatic expect_at(input int k, input logic o, input logic b, input int c);
    rec_t r;
    r.at = base + k; r.o = o; r.b = b; r.c = c; r.name = tname;
    sb.push_back(r);
  endtask

  // Advance until edge k of the current test has happened; caller then drives for edge k+1.
  task automatic at_edge(input int k);
    while (cyc < base + k) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic begin_put(input int v, input int m, input int p);
    value = 8'(v); mode = 2'(m); prescale = 4'(p); put = 1'b1;
    base = cyc + 1;
  endtask

  task automatic end_put();
    at_edge(0);
    put = 1'b0; cancel = 1'b0;
  endtask

  int strobe_cnt[21] = '{5,4,3,2,1,5,5,5,5,4,3,2,1,5,4,3,2,1,5,4,0};

  initial begin
    rec_t r;
    reset = 1'b1; put = 1'b1; value = 8'd9; mode = 2'd2; prescale = 4'd0;
    pause = 1'b0; cancel = 1'b0;

    fork
      forever begin
        @(negedge clock);
        while (sb.size() > 0 && sb[0].at <= cyc) begin
          r = sb.pop_front();
          total++;
          if (r.at != cyc || out !== r.o || busy !== r.b ||
              (r.c >= 0 && count !== 8'(r.c))) begin
            bad++;
            $display("FAIL %s edge=%0d: got out=%b busy=%b count=%0d, want out=%b busy=%b count=%0d",
                     r.name, r.at - base, out, busy, count, r.o, r.b, r.c);
          end
        end
      end
    join_none

    // Reset wins over a simultaneous put.
    base = 1;
    expect_at(0, 1'b0, 1'b0, 0);
    expect_at(1, 1'b0, 1'b0, 0);
    at_edge(1);
    reset = 1'b0; put = 1'b0;

    tname = "alarm";
    begin_put(8'h11, 0, 0);
    expect_at(0, 1'b0, 1'b1, 17);
    for (int k = 1; k <= 18; k++)
      expect_at(k, k == 17, k < 17, (k < 17) ? 17 - k : 0);
    end_put();
    mode = 2'd3; prescale = 4'd7; value = 8'h55;
    at_edge(20);

    tname = "timeout";
    begin_put(5, 1, 3);
    for (int k = 0; k <= 33; k++)
      if (k < 20) expect_at(k, 1'b0, 1'b1, 5 - k / 4);
      else expect_at(k, (k <= 30), 1'b0, 0);
    end_put();
    at_edge(30);
    cancel = 1'b1;
    at_edge(31);
    cancel = 1'b0;
    at_edge(34);

    tname = "pulse";
    begin_put(4, 2, 1);
    for (int k = 0; k <= 9; k++)
      expect_at(k, k < 8, k < 8, (k < 8) ? 4 - k / 2 : 0);
    end_put();
    at_edge(10);

    tname = "pulse_retrig";
    begin_put(4, 2, 1);
    for (int k = 0; k <= 14; k++)
      expect_at(k, k < 13, k < 13,
                (k < 5) ? 4 - k / 2 : (k < 13) ? 4 - (k - 5) / 2 : 0);
    end_put();
    at_edge(4);
    begin_put(4, 2, 1);
    base = base - 5;
    at_edge(5);
    put = 1'b0;
    at_edge(15);

    tname = "strobe_pause";
    begin_put(5, 3, 0);
    for (int k = 0; k <= 24; k++)
      expect_at(k, (k == 5 || k == 13 || k == 18), k < 20, (k <= 20) ? strobe_cnt[k] : 0);
    end_put();
    at_edge(5);
    pause = 1'b1;
    at_edge(8);
    pause = 1'b0;
    at_edge(19);
    cancel = 1'b1;
    at_edge(20);
    cancel = 1'b0;
    at_edge(25);

    tname = "strobe_every_clock";
    begin_put(1, 3, 0);
    for (int k = 0; k <= 6; k++)
      expect_at(k, (k >= 1 && k <= 4), k <= 4, (k <= 4) ? 1 : 0);
    end_put();
    at_edge(4);
    cancel = 1'b1;
    at_edge(5);
    cancel = 1'b0;
    at_edge(7);

    for (int m = 0; m < 4; m++) begin
      tname = $sformatf("zero_mode%0d", m);
      begin_put(0, m, 2);
      for (int k = 0; k <= 2; k++)
        expect_at(k, m == 1, 1'b0, 0);
      end_put();
      at_edge(3);
    end

    tname = "put_cancel";
    begin_put(3, 0, 0);
    cancel = 1'b1;
    for (int k = 0; k <= 4; k++)
      expect_at(k, k == 3, k < 3, (k < 3) ? 3 - k : 0);
    end_put();
    at_edge(5);

    tname = "reset_mid";
    begin_put(7, 3, 0);
    for (int k = 0; k <= 15; k++)
      expect_at(k, 1'b0, k < 4, (k < 4) ? 7 - k : 0);
    end_put();
    at_edge(3);
    reset = 1'b1;
    at_edge(4);
    reset = 1'b0;
    at_edge(17);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending checks, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000, want completion");
    $fatal(1, "watchdog");
  end

endmodule
